// File: rtl/timer_key_ctrl_pkg.sv
// Shared alarm-clock timer definitions: mode encodings,
// key indices and default timing for the key front-end.
package timer_key_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN       = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2
    } mode_e;

    localparam int DEF_DEBOUNCE_CYC = 4;
    localparam int DEF_REPEAT_DLY   = 8;
    localparam int DEF_REPEAT_PER   = 2;

    localparam int DISP_W = 14;

    localparam int KEY_MODE  = 0;
    localparam int KEY_HOUR  = 1;
    localparam int KEY_MIN   = 2;
    localparam int KEY_ALARM = 3;
    localparam int NUM_KEYS  = 4;

    function automatic mode_e mode_advance(input mode_e m);
        mode_e n;
        n = MODE_RUN;
        unique case (m)
            MODE_RUN:      n = MODE_SET_TIME;
            MODE_SET_TIME: n = MODE_SET_ALARM;
            default:       n = MODE_RUN;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus counting debouncer with
// registered rise/fall strobes on the debounced level.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            cnt_q      <= '0;
            level      <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            if (sync2_q == level) begin
                cnt_q <= '0;
            end else if (cnt_q >= CNT_LAST) begin
                level      <= sync2_q;
                cnt_q      <= '0;
                rise_pulse <= sync2_q;
                fall_pulse <= !sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_key_ctrl.sv
// Key front-end for the alarm-clock Timer: debounced keys,
// RUN/SET_TIME/SET_ALARM mode FSM, auto-repeat increment pulses.
import timer_key_ctrl_pkg::*;

module timer_key_ctrl #(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DLY   = DEF_REPEAT_DLY,
    parameter int REPEAT_PER   = DEF_REPEAT_PER,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_mode,
    input  logic       key_hour,
    input  logic       key_min,
    input  logic       key_alarm_en,
    output logic       set_time,
    output logic       alarm,
    output logic       hours_set,
    output logic       mins_set,
    output logic       Toggle_switch,
    output logic [1:0] mode_state
);

    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PER - 1);

    logic [NUM_KEYS-1:0] raw;
    logic [NUM_KEYS-1:0] lvl;
    logic [NUM_KEYS-1:0] rise;
    logic [NUM_KEYS-1:0] fall;

    assign raw = {key_alarm_en, key_min, key_hour, key_mode};

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_db
        key_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .CNT_W       (CNT_W)
        ) u_db (
            .clk       (clk),
            .reset_n   (reset_n),
            .raw       (raw[i]),
            .level     (lvl[i]),
            .rise_pulse(rise[i]),
            .fall_pulse(fall[i])
        );
    end

    mode_e state_q;
    mode_e state_d;
    logic  set_time_q;
    logic  alarm_q;
    logic  toggle_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= MODE_RUN;
            set_time_q <= 1'b0;
            alarm_q    <= 1'b0;
            toggle_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            set_time_q <= (state_d == MODE_SET_TIME);
            alarm_q    <= (state_d == MODE_SET_ALARM);
            toggle_q   <= lvl[KEY_ALARM] && (state_q == MODE_RUN);
        end
    end

    always_comb begin
        state_d = state_q;
        if (rise[KEY_MODE]) begin
            state_d = mode_advance(state_q);
        end
    end

    // A pending mode change kills the channels in the same cycle.
    logic in_set;
    assign in_set = (state_q != MODE_RUN) && !rise[KEY_MODE];

    for (genvar g = 0; g < 2; g++) begin : g_ch
        localparam int K = KEY_HOUR + g;

        logic             armed_q;
        logic             rep_q;
        logic             pulse_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] lim;

        assign lim = rep_q ? PER_LAST : DLY_LAST;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                armed_q <= 1'b0;
                rep_q   <= 1'b0;
                pulse_q <= 1'b0;
                cnt_q   <= '0;
            end else if (!in_set) begin
                armed_q <= 1'b0;
                rep_q   <= 1'b0;
                pulse_q <= 1'b0;
                cnt_q   <= '0;
            end else if (rise[K]) begin
                armed_q <= 1'b1;
                rep_q   <= 1'b0;
                pulse_q <= 1'b1;
                cnt_q   <= '0;
            end else if (armed_q && lvl[K]) begin
                if (cnt_q >= lim) begin
                    rep_q   <= 1'b1;
                    pulse_q <= 1'b1;
                    cnt_q   <= '0;
                end else begin
                    pulse_q <= 1'b0;
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end else begin
                armed_q <= 1'b0;
                rep_q   <= 1'b0;
                pulse_q <= 1'b0;
                cnt_q   <= '0;
            end
        end
    end

    assign set_time      = set_time_q;
    assign alarm         = alarm_q;
    assign hours_set     = g_ch[0].pulse_q;
    assign mins_set      = g_ch[1].pulse_q;
    assign Toggle_switch = toggle_q;
    assign mode_state    = state_q;

    logic unused_ok;
    assign unused_ok = ^{fall, rise[KEY_ALARM], lvl[KEY_MODE]};

endmodule

// File: tb/tb_timer_key_ctrl.sv
// Bench for timer_key_ctrl: directed scenarios plus random key
// activity checked against an event-level reference model.
module tb_timer_key_ctrl;

    localparam int DB  = 4;
    localparam int DLY = 8;
    localparam int PER = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] raw_v = '0;
    logic       set_time;
    logic       alarm;
    logic       hours_set;
    logic       mins_set;
    logic       Toggle_switch;
    logic [1:0] mode_state;

    always #5 clk = ~clk;

    timer_key_ctrl #(
        .DEBOUNCE_CYC(DB),
        .REPEAT_DLY  (DLY),
        .REPEAT_PER  (PER),
        .CNT_W       (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .key_mode     (raw_v[0]),
        .key_hour     (raw_v[1]),
        .key_min      (raw_v[2]),
        .key_alarm_en (raw_v[3]),
        .set_time     (set_time),
        .alarm        (alarm),
        .hours_set    (hours_set),
        .mins_set     (mins_set),
        .Toggle_switch(Toggle_switch),
        .mode_state   (mode_state)
    );

    int tests = 0;
    int fails = 0;
    int edge_n = 0;

    bit m_s1 [4];
    bit m_s2 [4];
    bit m_lvl [4];
    bit m_rise [4];
    bit m_hist [4][DB];
    int m_mode;
    int m_start [2];
    bit e_set, e_alm, e_hr, e_mn, e_tog;
    int e_mode;

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_s1[i] = 0;
            m_s2[i] = 0;
            m_lvl[i] = 0;
            m_rise[i] = 0;
            for (int j = 0; j < DB; j++) m_hist[i][j] = 0;
        end
        m_mode = 0;
        m_start[0] = -1;
        m_start[1] = -1;
        {e_set, e_alm, e_hr, e_mn, e_tog} = '0;
        e_mode = 0;
    endtask

    // Event-level model: a level flips once DB consecutive synced
    // samples disagree with it; pulses at press and at DLY + n*PER.
    task automatic model_edge();
        int nm;
        int d;
        bit p;
        bit all;
        nm = m_rise[0] ? ((m_mode == 2) ? 0 : m_mode + 1) : m_mode;
        e_mode = nm;
        e_set = (nm == 1);
        e_alm = (nm == 2);
        e_tog = m_lvl[3] && (m_mode == 0);
        for (int c = 0; c < 2; c++) begin
            p = 0;
            if (m_mode == 0 || m_rise[0]) begin
                m_start[c] = -1;
            end else if (m_rise[c+1]) begin
                m_start[c] = edge_n;
                p = 1;
            end else if (m_start[c] >= 0 && m_lvl[c+1]) begin
                d = edge_n - m_start[c];
                p = (d >= DLY) && ((d - DLY) % PER == 0);
            end else begin
                m_start[c] = -1;
            end
            if (c == 0) e_hr = p;
            else e_mn = p;
        end
        m_mode = nm;
        for (int i = 0; i < 4; i++) begin
            for (int j = DB - 1; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
            m_hist[i][0] = m_s2[i];
            all = 1;
            for (int j = 0; j < DB; j++)
                if (m_hist[i][j] == m_lvl[i]) all = 0;
            m_rise[i] = 0;
            if (all) begin
                m_lvl[i] = !m_lvl[i];
                m_rise[i] = m_lvl[i];
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = raw_v[i];
        end
        edge_n++;
    endtask

    task automatic check_all();
        check_int("mode_state", int'(mode_state), e_mode);
        check("set_time", set_time, e_set);
        check("alarm", alarm, e_alm);
        check("hours_set", hours_set, e_hr);
        check("mins_set", mins_set, e_mn);
        check("Toggle_switch", Toggle_switch, e_tog);
        check("set_excl", set_time & alarm, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2;
        reset_n = 1'b1;
    endtask

    task automatic press(input int k, input int hold);
        raw_v[k] = 1'b1;
        ticks(hold);
        raw_v[k] = 1'b0;
        ticks(12);
    endtask

    int cnt, first, last, tm, tt;
    int hold_left [4];

    initial begin
        model_reset();
        #2;
        check_all();
        #1;
        reset_n = 1'b1;
        ticks(5);

        // first mode press: SET_TIME after L edges
        first = -1;
        raw_v[0] = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (set_time && first < 0) first = t;
        end
        raw_v[0] = 1'b0;
        ticks(12);
        check_int("mode_latency", first, 7);
        check_int("mode_1", int'(mode_state), 1);
        press(0, 10);
        check_int("mode_2", int'(mode_state), 2);
        press(0, 10);
        check_int("mode_0", int'(mode_state), 0);
        press(0, 10);

        // 3-cycle glitch is rejected
        cnt = 0;
        raw_v[1] = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            tick();
            cnt += int'(hours_set);
        end
        raw_v[1] = 1'b0;
        for (int t = 1; t <= 15; t++) begin
            tick();
            cnt += int'(hours_set);
        end
        check_int("glitch3_pulses", cnt, 0);

        // bounce then short stable press: one pulse
        cnt = 0;
        raw_v[1] = 1'b1;
        for (int t = 1; t <= 25; t++) begin
            tick();
            cnt += int'(hours_set);
            if (t == 4) raw_v[1] = 1'b0;
            if (t == 5) raw_v[1] = 1'b1;
            if (t == 8) raw_v[1] = 1'b0;
        end
        check_int("bounce_pulses", cnt, 1);

        // auto-repeat: held for edges 1..19
        cnt = 0;
        first = -1;
        last = -1;
        raw_v[1] = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (hours_set) begin
                cnt++;
                if (first < 0) first = t;
                last = t;
            end
            if (t == 19) raw_v[1] = 1'b0;
        end
        check_int("repeat_count", cnt, 7);
        check_int("repeat_first", first, 7);
        check_int("repeat_last", last, 25);

        // SET_ALARM with alarm switch on: Toggle stays low
        press(0, 10);
        raw_v[3] = 1'b1;
        ticks(12);
        check("toggle_in_set", Toggle_switch, 1'b0);

        // min held, mode returns to RUN: pulses stop, Toggle follows
        raw_v[2] = 1'b1;
        ticks(20);
        raw_v[0] = 1'b1;
        tm = -1;
        tt = -1;
        cnt = 0;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (mode_state == 2'd0 && tm < 0) tm = t;
            if (Toggle_switch && tt < 0) tt = t;
            if (tm > 0) cnt += int'(mins_set);
            if (t == 12) raw_v[0] = 1'b0;
        end
        check_int("run_latency", tm, 7);
        check_int("toggle_on", tt, 8);
        check_int("min_after_run", cnt, 0);

        // fresh press in RUN is ignored
        raw_v[2] = 1'b0;
        ticks(12);
        cnt = 0;
        raw_v[2] = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            cnt += int'(mins_set);
        end
        check_int("min_in_run", cnt, 0);

        // alarm switch off: Toggle falls after L
        raw_v[3] = 1'b0;
        first = -1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (!Toggle_switch && first < 0) first = t;
        end
        check_int("toggle_off", first, 7);

        // enter SET_TIME with min held: nothing until re-press
        cnt = 0;
        raw_v[0] = 1'b1;
        for (int t = 1; t <= 25; t++) begin
            tick();
            cnt += int'(mins_set);
            if (t == 10) raw_v[0] = 1'b0;
        end
        check_int("held_into_set", cnt, 0);
        raw_v[2] = 1'b0;
        ticks(12);
        cnt = 0;
        raw_v[2] = 1'b1;
        for (int t = 1; t <= 25; t++) begin
            tick();
            cnt += int'(mins_set);
            if (t == 10) raw_v[2] = 1'b0;
        end
        check_int("repress_pulses", cnt, 2);

        // reset mid-repeat with mode key held across release
        raw_v[1] = 1'b1;
        ticks(20);
        raw_v[0] = 1'b1;
        do_reset();
        check_int("reset_mode", int'(mode_state), 0);
        first = -1;
        cnt = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            cnt += int'(hours_set);
            if (mode_state == 2'd1 && first < 0) first = t;
        end
        check_int("post_reset_latency", first, 7);
        check_int("post_reset_hours", cnt, 0);
        raw_v = '0;
        ticks(12);

        // random key activity against the model
        for (int i = 0; i < 4; i++) hold_left[i] = 1;
        for (int n = 0; n < 4000; n++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                hold_left[i]--;
                if (hold_left[i] <= 0) begin
                    raw_v[i] = !raw_v[i];
                    hold_left[i] = (i == 0) ?
                        int'($urandom_range(1, 60)) :
                        int'($urandom_range(1, 25));
                end
            end
            if ($urandom_range(0, 799) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/timer_key_ctrl.md
Name: timer_key_ctrl

Overview:
- Front-end for the alarm-clock Timer.
- Takes raw push-buttons and the alarm slide switch and produces the Timer's control inputs: set_time, alarm, hours_set, mins_set and Toggle_switch.
- Each input is synchronised and debounced. A mode state machine runs RUN -> SET_TIME -> SET_ALARM -> RUN.
- hours_set/mins_set are single-cycle pulses, with auto-repeat while a key is held.

Parameters:
- DEBOUNCE_CYC, 4: consecutive stable synchronized samples required before a debounced level changes (min 1).
- REPEAT_DLY, 8: cycles from the first pulse to the first auto-repeat pulse.
- REPEAT_PER, 2: cycles between auto-repeat pulses (min 2, so there is always a low cycle between pulses).
- CNT_W, 8: width of the debounce and repeat counters; must hold max(DEBOUNCE_CYC, REPEAT_DLY).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- key_mode  in  1  raw mode button, active high
- key_hour  in  1  raw hour-advance button, active high
- key_min  in  1  raw minute-advance button, active high
- key_alarm_en  in  1  raw alarm-enable slide switch
- set_time  out  1  high while the mode is SET_TIME
- alarm  out  1  high while the mode is SET_ALARM
- hours_set  out  1  one-cycle hour-increment pulse
- mins_set  out  1  one-cycle minute-increment pulse
- Toggle_switch  out  1  debounced alarm enable, forced 0 outside RUN
- mode_state  out  2  0 = RUN, 1 = SET_TIME, 2 = SET_ALARM; 3 is unused

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset_n is asynchronous and active low.
  - On reset, every output is 0, mode is RUN, and all synchronizers, debounced levels and counters are 0.
  - Assertion of reset mid-press or mid-repeat aborts it immediately. After release, a still-held key must first debounce high again; there is no pulse from a pre-reset press.
- Input conditioning:
  - Each raw input passes a 2-flop synchronizer. The synchronized value lags the raw input by 2 edges.
  - Debounce: the counter increments on each edge where the synchronized value differs from the debounced level, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYC, the level flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYC cycles never reach the outputs.
- Press latency:
  - For a raw change first sampled at edge k, the debounced level flips at edge k+DEBOUNCE_CYC+1.
  - The registered output pulse is high for the cycle after edge k+DEBOUNCE_CYC+2.
  - L = DEBOUNCE_CYC+3 edges; L = 7 with defaults.
- Mode FSM:
  - Advances one state on each debounced rising edge of key_mode.
  - Outputs are registered: set_time = (state == SET_TIME) and alarm = (state == SET_ALARM). They are never both 1.
- Increment keys:
  - Active only in SET_TIME or SET_ALARM.
  - On a debounced rise, hours_set (or mins_set) pulses for 1 cycle.
  - While the key stays debounced-high, the next pulse comes REPEAT_DLY cycles after the first, then every REPEAT_PER cycles.
  - Repeat stops on the debounced fall. No pulse is issued in the cycle where the level is already low.
- Both increment keys held: the hour and minute channels are independent, and pulses may coincide.
- Mode change while an increment key is held:
  - Pulses and the repeat counter stop the cycle the mode leaves a set state.
  - Entering the next set state with the key still held produces no pulse until release and re-press; each channel has an armed flag that is cleared on a mode change.
  - In RUN, increment keys are ignored entirely and produce no pulses.
- Toggle_switch = debounced key_alarm_en AND (state == RUN), registered.
- Counters saturate; they never wrap. A held key repeats indefinitely at REPEAT_PER.

Decomposition:
- Shared timer package holds:
  - mode encodings MODE_RUN = 2'd0, MODE_SET_TIME = 2'd1, MODE_SET_ALARM = 2'd2;
  - default DEBOUNCE_CYC, REPEAT_DLY, REPEAT_PER;
  - the 14-bit display width constant already used by the Timer.
- One sub-module, key_debounce (params DEBOUNCE_CYC, CNT_W):
  - inputs clk, reset_n, raw;
  - outputs level, rise_pulse, fall_pulse;
  - instantiated four times.
- The mode FSM and two auto-repeat channels live in the top; the repeat channel may be a generate loop.

Test Plan:
- Reset: assert reset_n = 0 mid-repeat -> all outputs 0 within the same cycle, mode_state = 0. Release while the key is held -> first pulse L = 7 edges after release.
- Glitch rejection: in SET_TIME, key_hour high 3 cycles then low -> no hours_set pulse. A 4-cycle bounce followed by a stable press -> exactly one pulse.
- Mode cycling: three clean key_mode presses -> mode_state 1, 2, 0. set_time and alarm track the state with the same latency L and are never both high.
- Auto-repeat: in SET_TIME, key_hour raw-high for edges 0..19 -> hours_set high after edges 7, 15, 17, 19, 21, 23, 25 (7 pulses), none after.
- Gating: key_min pressed in RUN -> no mins_set. key_min held while switching SET_ALARM -> RUN -> pulses stop that cycle and do not resume until release and re-press.
- Alarm enable: key_alarm_en = 1 in SET_ALARM -> Toggle_switch = 0. After the mode returns to RUN -> Toggle_switch = 1 one cycle later. Switch to 0 -> Toggle_switch falls L edges after the change.
